// File: rtl/spu_pipe_pkg.sv
// Shared types and helpers for the SPU result-holding pipeline.
// Holds the default widths, the per-stage entry layout and the latency countdown.
// No logic of its own; imported by the stage and the top.
package spu_pipe_pkg;

    localparam int P_NUM_PIPES = 2;
    localparam int P_DEPTH     = 7;
    localparam int P_DATA_W    = 128;
    localparam int P_SIDE_W    = 128;
    localparam int P_ADDR_W    = 7;
    localparam int P_UNIT_W    = 3;
    localparam int P_LAT_W     = 3;
    localparam int P_NUM_RD    = 3;

    // One in-flight result as it travels down a pipe.
    typedef struct packed {
        logic                we;
        logic [P_DATA_W-1:0] result;
        logic [P_ADDR_W-1:0] rt;
        logic [P_UNIT_W-1:0] unit;
        logic [P_LAT_W-1:0]  lat;
        logic [P_SIDE_W-1:0] side;
    } pipe_entry_t;

    // Cycles-until-ready countdown; sticks at zero so a ready result never looks un-ready again.
    function automatic logic [P_LAT_W-1:0] lat_dec(input logic [P_LAT_W-1:0] lat);
        return (lat != '0) ? (lat - P_LAT_W'(1)) : '0;
    endfunction

endpackage

// File: rtl/spu_result_stage.sv
// One register stage holding one entry per pipe; latency counts down on every load.
// Latency: 1 cycle. Flush clears the write enable of the entry being loaded.
// No backpressure: the stage loads unconditionally every cycle.
module spu_result_stage
    import spu_pipe_pkg::*;
#(
    parameter int NUM_PIPES = P_NUM_PIPES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PIPES-1:0]          i_flush,
    input  pipe_entry_t [NUM_PIPES-1:0]   i_entry,
    output pipe_entry_t [NUM_PIPES-1:0]   o_entry
);

    pipe_entry_t [NUM_PIPES-1:0] r_entry;
    pipe_entry_t [NUM_PIPES-1:0] w_next;

    // Next entry: copy the upstream entry, count its latency down, drop its write on flush.
    always_comb begin
        w_next = i_entry;
        for (int p = 0; p < NUM_PIPES; p++) begin
            w_next[p].lat = lat_dec(i_entry[p].lat);
            if (i_flush[p]) begin
                w_next[p].we = 1'b0;
            end
        end
    end

    // Stage register; reset clears every field, data included.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry <= '0;
        end else begin
            r_entry <= w_next;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/spu_result_pipe.sv
// Multi-pipe result-holding pipeline with forwarding lookup and last-stage writeback.
// Latency: DEPTH cycles from in_* to wb_*; forwarding is combinational off the stage registers.
// No backpressure: entries advance every cycle; consumers stall on rd_pending themselves.
module spu_result_pipe
    import spu_pipe_pkg::*;
#(
    parameter int NUM_PIPES = P_NUM_PIPES,
    parameter int DEPTH     = P_DEPTH,
    parameter int DATA_W    = P_DATA_W,
    parameter int SIDE_W    = P_SIDE_W,
    parameter int ADDR_W    = P_ADDR_W,
    parameter int UNIT_W    = P_UNIT_W,
    parameter int LAT_W     = P_LAT_W,
    parameter int NUM_RD    = P_NUM_RD
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PIPES-1:0]          in_we,
    input  logic [NUM_PIPES*DATA_W-1:0]   in_result,
    input  logic [NUM_PIPES*ADDR_W-1:0]   in_rt,
    input  logic [NUM_PIPES*UNIT_W-1:0]   in_unit,
    input  logic [NUM_PIPES*LAT_W-1:0]    in_lat,
    input  logic [NUM_PIPES*SIDE_W-1:0]   in_side,
    input  logic [NUM_PIPES-1:0]          flush,
    input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
    output logic [NUM_RD-1:0]             rd_hit,
    output logic [NUM_RD*DATA_W-1:0]      rd_data,
    output logic [NUM_RD-1:0]             rd_pending,
    output logic [NUM_PIPES-1:0]          wb_we,
    output logic [NUM_PIPES*DATA_W-1:0]   wb_result,
    output logic [NUM_PIPES*ADDR_W-1:0]   wb_rt,
    output logic [NUM_PIPES*UNIT_W-1:0]   wb_unit,
    output logic [NUM_PIPES*SIDE_W-1:0]   wb_side,
    output logic [NUM_PIPES*LAT_W-1:0]    wb_lat
);

    // The entry layout is shared through the package, so the width parameters
    // are expected to stay at the package values.
    pipe_entry_t [NUM_PIPES-1:0] w_in;
    pipe_entry_t [NUM_PIPES-1:0] w_stage [DEPTH];

    logic [NUM_RD-1:0] w_fwd_vld;
    logic [NUM_RD-1:0] w_fwd_rdy;
    logic [DATA_W-1:0] w_fwd_dat [NUM_RD];

    // Gather the flat per-pipe issue inputs into stage-0 entries.
    always_comb begin
        w_in = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            w_in[p].we     = in_we[p];
            w_in[p].result = in_result[p*DATA_W +: DATA_W];
            w_in[p].rt     = in_rt[p*ADDR_W +: ADDR_W];
            w_in[p].unit   = in_unit[p*UNIT_W +: UNIT_W];
            w_in[p].lat    = in_lat[p*LAT_W +: LAT_W];
            w_in[p].side   = in_side[p*SIDE_W +: SIDE_W];
        end
    end

    // Chain of DEPTH stages; every stage sees the same flush so a whole pipe empties at once.
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_first
            spu_result_stage #(
                .NUM_PIPES (NUM_PIPES)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_flush (flush),
                .i_entry (w_in),
                .o_entry (w_stage[s])
            );
        end else begin : g_next
            spu_result_stage #(
                .NUM_PIPES (NUM_PIPES)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_flush (flush),
                .i_entry (w_stage[s-1]),
                .o_entry (w_stage[s])
            );
        end
    end

    // Youngest-match search: walk oldest to youngest so the last hit written wins.
    // Within a stage the higher pipe is later in program order, so it is visited last.
    always_comb begin
        w_fwd_vld = '0;
        w_fwd_rdy = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            w_fwd_dat[q] = '0;
        end
        for (int q = 0; q < NUM_RD; q++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int p = 0; p < NUM_PIPES; p++) begin
                    if (w_stage[s][p].we && (w_stage[s][p].rt == rd_addr[q*ADDR_W +: ADDR_W])) begin
                        w_fwd_vld[q] = 1'b1;
                        w_fwd_rdy[q] = (w_stage[s][p].lat == '0);
                        w_fwd_dat[q] = w_stage[s][p].result;
                    end
                end
            end
        end
    end

    // A younger match that is still counting down hides any older ready copy.
    always_comb begin
        rd_hit     = w_fwd_vld & w_fwd_rdy;
        rd_pending = w_fwd_vld & ~w_fwd_rdy;
        rd_data    = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            if (w_fwd_vld[q] && w_fwd_rdy[q]) begin
                rd_data[q*DATA_W +: DATA_W] = w_fwd_dat[q];
            end
        end
    end

    // Writeback straight from the last stage registers.
    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_wb
        assign wb_we[p]                      = w_stage[DEPTH-1][p].we;
        assign wb_result[p*DATA_W +: DATA_W] = w_stage[DEPTH-1][p].result;
        assign wb_rt[p*ADDR_W +: ADDR_W]     = w_stage[DEPTH-1][p].rt;
        assign wb_unit[p*UNIT_W +: UNIT_W]   = w_stage[DEPTH-1][p].unit;
        assign wb_side[p*SIDE_W +: SIDE_W]   = w_stage[DEPTH-1][p].side;
        assign wb_lat[p*LAT_W +: LAT_W]      = w_stage[DEPTH-1][p].lat;
    end

endmodule

// File: tb/tb_spu_result_pipe.sv
// Bench for spu_result_pipe: queue scoreboard of per-pipe stage contents plus directed checks.
// Outputs are sampled on the falling edge, inputs driven right after sampling.
// Writeback and forwarding expectations are derived from the queued stimulus.
module tb_spu_result_pipe;
    import spu_pipe_pkg::*;

    localparam int NP = P_NUM_PIPES;
    localparam int DP = P_DEPTH;
    localparam int DW = P_DATA_W;
    localparam int SW = P_SIDE_W;
    localparam int AW = P_ADDR_W;
    localparam int UW = P_UNIT_W;
    localparam int LW = P_LAT_W;
    localparam int NR = P_NUM_RD;

    logic               clk;
    logic               reset;
    logic [NP-1:0]      in_we;
    logic [NP*DW-1:0]   in_result;
    logic [NP*AW-1:0]   in_rt;
    logic [NP*UW-1:0]   in_unit;
    logic [NP*LW-1:0]   in_lat;
    logic [NP*SW-1:0]   in_side;
    logic [NP-1:0]      flush;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR-1:0]      rd_hit;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_pending;
    logic [NP-1:0]      wb_we;
    logic [NP*DW-1:0]   wb_result;
    logic [NP*AW-1:0]   wb_rt;
    logic [NP*UW-1:0]   wb_unit;
    logic [NP*SW-1:0]   wb_side;
    logic [NP*LW-1:0]   wb_lat;

    spu_result_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_we      (in_we),
        .in_result  (in_result),
        .in_rt      (in_rt),
        .in_unit    (in_unit),
        .in_lat     (in_lat),
        .in_side    (in_side),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .wb_we      (wb_we),
        .wb_result  (wb_result),
        .wb_rt      (wb_rt),
        .wb_unit    (wb_unit),
        .wb_side    (wb_side),
        .wb_lat     (wb_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard: per pipe, DP entries; index 0 is the oldest (last stage), lat kept as issued.
    pipe_entry_t mdl_q [NP][$];
    pipe_entry_t drv [NP];
    logic [AW-1:0] rd_a [NR];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Latency an entry issued with l should show while sitting in stage s.
    function automatic logic [LW-1:0] exp_lat(input logic [LW-1:0] l, input int s);
        int v;
        v = int'(l) - s - 1;
        return (v < 0) ? '0 : LW'(v);
    endfunction

    function automatic pipe_entry_t rnd_entry(input logic we);
        pipe_entry_t e;
        e.we     = we;
        e.result = {$urandom, $urandom, $urandom, $urandom};
        e.rt     = AW'($urandom_range(0, 127));
        e.unit   = UW'($urandom_range(0, 7));
        e.lat    = LW'($urandom_range(0, 7));
        e.side   = {$urandom, $urandom, $urandom, $urandom};
        return e;
    endfunction

    task automatic idle();
        for (int p = 0; p < NP; p++) drv[p] = rnd_entry(1'b0);
    endtask

    task automatic set_ent(input int p, input logic [AW-1:0] rt, input logic [LW-1:0] lat,
                           input logic [DW-1:0] res);
        drv[p]        = rnd_entry(1'b1);
        drv[p].rt     = rt;
        drv[p].lat    = lat;
        drv[p].result = res;
    endtask

    // Apply drv/rd_a to the ports and advance the scoreboard to the post-edge state.
    task automatic drive(input logic [NP-1:0] fl, input logic rst);
        pipe_entry_t e;
        for (int p = 0; p < NP; p++) begin
            in_we[p]               = drv[p].we;
            in_result[p*DW +: DW]  = drv[p].result;
            in_rt[p*AW +: AW]      = drv[p].rt;
            in_unit[p*UW +: UW]    = drv[p].unit;
            in_lat[p*LW +: LW]     = drv[p].lat;
            in_side[p*SW +: SW]    = drv[p].side;
        end
        for (int q = 0; q < NR; q++) rd_addr[q*AW +: AW] = rd_a[q];
        flush = fl;
        reset = rst;
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                mdl_q[p].delete();
                for (int i = 0; i < DP; i++) mdl_q[p].push_back('0);
            end else begin
                if (fl[p]) begin
                    for (int i = 0; i < DP; i++) begin
                        e = mdl_q[p][i];
                        e.we = 1'b0;
                        mdl_q[p][i] = e;
                    end
                end
                e = drv[p];
                if (fl[p]) e.we = 1'b0;
                mdl_q[p].push_back(e);
                void'(mdl_q[p].pop_front());
            end
        end
    endtask

    // Wait for the falling edge and compare every output against the scoreboard.
    task automatic tick();
        pipe_entry_t e;
        logic hit, pend, found;
        logic [DW-1:0] dat;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            e = mdl_q[p][0];
            chk($sformatf("wb_we[%0d]", p),     wb_we[p],              e.we);
            chk($sformatf("wb_rt[%0d]", p),     wb_rt[p*AW +: AW],     e.rt);
            chk($sformatf("wb_result[%0d]", p), wb_result[p*DW +: DW], e.result);
            chk($sformatf("wb_unit[%0d]", p),   wb_unit[p*UW +: UW],   e.unit);
            chk($sformatf("wb_side[%0d]", p),   wb_side[p*SW +: SW],   e.side);
            chk($sformatf("wb_lat[%0d]", p),    wb_lat[p*LW +: LW],    exp_lat(e.lat, DP - 1));
        end
        for (int q = 0; q < NR; q++) begin
            hit = 1'b0; pend = 1'b0; found = 1'b0; dat = '0;
            for (int s = 0; s < DP && !found; s++) begin
                for (int p = NP - 1; p >= 0 && !found; p--) begin
                    e = mdl_q[p][DP-1-s];
                    if (e.we && e.rt == rd_a[q]) begin
                        found = 1'b1;
                        if (exp_lat(e.lat, s) == '0) begin
                            hit = 1'b1;
                            dat = e.result;
                        end else begin
                            pend = 1'b1;
                        end
                    end
                end
            end
            chk($sformatf("rd_hit[%0d]", q),     rd_hit[q],             hit);
            chk($sformatf("rd_pending[%0d]", q), rd_pending[q],         pend);
            chk($sformatf("rd_data[%0d]", q),    rd_data[q*DW +: DW],   dat);
        end
    endtask

    task automatic drain();
        for (int i = 0; i <= DP; i++) begin
            idle();
            drive('0, 1'b0);
            tick();
        end
    endtask

    int cnt0, cnt1;

    initial begin
        // Reset held with busy-looking inputs.
        for (int p = 0; p < NP; p++) begin
            drv[p]        = '1;
            drv[p].lat    = LW'(5);
        end
        rd_a[0] = AW'(10); rd_a[1] = AW'(5); rd_a[2] = AW'(20);
        drive('0, 1'b1);
        tick();
        drive('0, 1'b1);
        tick();
        idle();
        drive('0, 1'b0);
        #1;
        chk("rst_wb_we",    wb_we,      '0);
        chk("rst_wb_res",   wb_result,  '0);
        chk("rst_wb_lat",   wb_lat,     '0);
        chk("rst_rd_hit",   rd_hit,     '0);
        chk("rst_rd_pend",  rd_pending, '0);
        tick();
        drain();

        // Countdown: lat 3 entry on pipe 0.
        idle();
        set_ent(0, AW'(10), LW'(3), DW'(128'hA5));
        drive('0, 1'b0);
        tick();
        chk("cd_pend_s0", rd_pending[0], 1'b1);
        idle(); drive('0, 1'b0); tick();
        chk("cd_pend_s1", rd_pending[0], 1'b1);
        idle(); drive('0, 1'b0); tick();
        chk("cd_hit_s2",  rd_hit[0], 1'b1);
        chk("cd_data_s2", rd_data[DW-1:0], 128'hA5);
        for (int i = 4; i <= DP; i++) begin
            idle(); drive('0, 1'b0); tick();
        end
        chk("cd_wb_we",  wb_we[0], 1'b1);
        chk("cd_wb_rt",  wb_rt[AW-1:0], 7'd10);
        chk("cd_wb_lat", wb_lat[LW-1:0], 3'd0);
        drain();

        // Priority: younger pending copy hides older ready copy; same stage -> pipe 1 wins.
        idle(); set_ent(0, AW'(5), LW'(0), DW'(128'h11));
        drive('0, 1'b0); tick();
        chk("pri_old_hit", rd_data[DW +: DW], 128'h11);
        idle(); set_ent(1, AW'(5), LW'(2), DW'(128'h22));
        drive('0, 1'b0); tick();
        chk("pri_young_pend", rd_pending[1], 1'b1);
        chk("pri_young_nohit", rd_hit[1], 1'b0);
        idle();
        set_ent(0, AW'(5), LW'(0), DW'(128'h11));
        set_ent(1, AW'(5), LW'(0), DW'(128'h22));
        drive('0, 1'b0); tick();
        chk("pri_same_stage", rd_data[DW +: DW], 128'h22);
        drain();

        // Saturation: lat 0 stays 0 through every stage.
        idle(); set_ent(0, AW'(20), LW'(0), DW'(128'h3C));
        drive('0, 1'b0);
        for (int i = 1; i <= DP; i++) begin
            tick();
            chk("sat_hit", rd_hit[2], 1'b1);
            idle(); drive('0, 1'b0);
        end
        chk("sat_wb_lat", wb_lat[LW-1:0], 3'd0);
        tick();
        drain();

        // Flush pipe 1 with three entries in flight plus one at the stage-0 input.
        for (int k = 0; k < 3; k++) begin
            idle();
            set_ent(0, AW'(40 + k), LW'(1), DW'(128'h40 + k));
            set_ent(1, AW'(30 + k), LW'(1), DW'(128'h30 + k));
            drive('0, 1'b0); tick();
        end
        idle(); set_ent(1, AW'(33), LW'(0), DW'(128'h33));
        drive(2'b10, 1'b0); tick();
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 10; i++) begin
            idle(); drive('0, 1'b0); tick();
            cnt0 += int'(wb_we[0]);
            cnt1 += int'(wb_we[1]);
        end
        chk("fl_p0_count", 128'(cnt0), 128'd3);
        chk("fl_p1_count", 128'(cnt1), 128'd0);

        // Reset mid-operation, with flush also asserted.
        for (int i = 0; i < DP; i++) begin
            idle();
            set_ent(0, AW'(50 + i), LW'(0), DW'(128'h50 + i));
            set_ent(1, AW'(50 + i), LW'(0), DW'(128'h60 + i));
            drive('0, 1'b0); tick();
        end
        rd_a[0] = AW'(50 + DP - 1);
        for (int p = 0; p < NP; p++) drv[p] = '1;
        drive(2'b11, 1'b1); tick();
        chk("mrst_wb_we", wb_we, '0);
        chk("mrst_rd_hit", rd_hit, '0);
        idle(); set_ent(0, AW'(60), LW'(1), DW'(128'h77));
        drive('0, 1'b0); tick();
        for (int i = 2; i <= DP; i++) begin
            idle(); drive('0, 1'b0); tick();
        end
        chk("mrst_inj_we", wb_we[0], 1'b1);
        chk("mrst_inj_rt", wb_rt[AW-1:0], 7'd60);
        chk("mrst_inj_res", wb_result[DW-1:0], 128'h77);

        // Random traffic over a small register set, with occasional flushes and resets.
        for (int c = 0; c < 300; c++) begin
            logic [NP-1:0] fl;
            logic rst;
            for (int p = 0; p < NP; p++) begin
                drv[p]    = rnd_entry(1'($urandom_range(0, 1)));
                drv[p].rt = AW'($urandom_range(0, 7));
                fl[p]     = ($urandom_range(0, 15) == 0);
            end
            for (int q = 0; q < NR; q++) rd_a[q] = AW'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            drive(fl, rst);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
